// File: rtl/xbus_feeder.sv
// X-bus feeder: per-column tag configuration over a lock handshake, then broadcast of a tagged word stream.
// Optional stall timeout is enabled by defining XBUS_TIMEOUT_EN.
module xbus_feeder #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_COL        = 4,
  parameter int TAG_W          = $clog2(NUM_COL) + 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cfg_start,
  input  logic [NUM_COL-1:0]       col_en,
  output logic [NUM_COL*TAG_W-1:0] tag_out,
  input  logic [NUM_COL-1:0]       tag_lock,
  output logic                     cfg_done,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic [TAG_W-1:0]         s_tag,
  input  logic                     s_last,
  output logic                     bus_valid,
  output logic [DATA_WIDTH-1:0]    bus_data,
  output logic [TAG_W-1:0]         bus_tag,
  input  logic [NUM_COL-1:0]       bus_ready,
  output logic                     frame_done,
  output logic                     err
);
  localparam int KW = $clog2(NUM_COL);

  typedef enum logic [2:0] {IDLE, CFG_DRIVE, CFG_WAIT, READY, STREAM} state_e;

  state_e                         state_q;
  logic [KW-1:0]                  k_q;
  logic [NUM_COL-1:0]             col_en_q;
  logic [NUM_COL-1:0][TAG_W-1:0]  tag_q;
  logic                           bus_valid_q;
  logic [DATA_WIDTH-1:0]          bus_data_q;
  logic [TAG_W-1:0]               bus_tag_q;
  logic                           last_q;
  logic                           err_q;

  logic all_rdy, retire, accept, k_last, cfg_restart;
  logic bus_to, cfg_to, retire_any;

  assign all_rdy     = &(bus_ready | ~col_en_q);
  assign retire      = bus_valid_q & all_rdy;
  assign k_last      = (k_q == KW'(NUM_COL - 1));
  assign cfg_restart = cfg_start & ((state_q == IDLE) | (state_q == READY));
  assign cfg_done    = (state_q == READY) | (state_q == STREAM);
  // A restart in READY takes priority over a word arriving in the same cycle.
  assign s_ready     = cfg_done & (~bus_valid_q | retire) & ~cfg_restart;
  assign accept      = s_valid & s_ready;
  assign retire_any  = retire | bus_to;

  assign tag_out    = tag_q;
  assign bus_valid  = bus_valid_q;
  assign bus_data   = bus_data_q;
  assign bus_tag    = bus_tag_q;
  assign frame_done = rstn & retire_any & last_q;

`ifdef XBUS_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        bus_stall, cfg_stall, cnt_hit;
  assign bus_stall = bus_valid_q & ~all_rdy;
  assign cfg_stall = (state_q == CFG_WAIT) & ~tag_lock[k_q];
  assign cnt_hit   = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign bus_to    = bus_stall & cnt_hit;
  assign cfg_to    = cfg_stall & cnt_hit;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (!rstn)                                  cnt_q <= '0;
    else if ((bus_stall | cfg_stall) & ~cnt_hit) cnt_q <= cnt_q + 16'd1;
    else                                        cnt_q <= '0;
  end
`else
  assign bus_to = 1'b0;
  assign cfg_to = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      k_q         <= '0;
      col_en_q    <= '0;
      tag_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      bus_tag_q   <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (cfg_restart) begin
        col_en_q <= col_en;
        k_q      <= '0;
        tag_q    <= '0;
        state_q  <= CFG_DRIVE;
      end else begin
        case (state_q)
          CFG_DRIVE: begin
            if (col_en_q[k_q]) begin
              tag_q[k_q] <= {1'b1, k_q};
              state_q    <= CFG_WAIT;
            end else begin
              tag_q[k_q] <= '0;
              if (k_last) state_q <= READY;
              else        k_q     <= k_q + KW'(1);
            end
          end
          CFG_WAIT: begin
            // A lock timeout skips the column but leaves its tag as driven.
            if (tag_lock[k_q] | cfg_to) begin
              if (k_last) state_q <= READY;
              else begin
                k_q     <= k_q + KW'(1);
                state_q <= CFG_DRIVE;
              end
            end
          end
          READY:   if (accept) state_q <= STREAM;
          STREAM:  if (retire_any & last_q & ~accept) state_q <= READY;
          default: ;
        endcase
      end

      if (accept) begin
        bus_valid_q <= 1'b1;
        bus_data_q  <= s_data;
        bus_tag_q   <= s_tag;
        last_q      <= s_last;
      end else if (retire_any) begin
        bus_valid_q <= 1'b0;
      end

      if (bus_to | cfg_to) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_xbus_feeder.sv
// Scoreboard bench for xbus_feeder: driver pushes expected words on accept, monitor pops on retire.
module tb_xbus_feeder;
  localparam int DW = 16, NC = 4, TW = 3;

  logic              clk, rstn, cfg_start;
  logic [NC-1:0]     col_en, tag_lock, bus_ready;
  logic [NC*TW-1:0]  tag_out;
  logic              cfg_done, s_valid, s_ready, s_last;
  logic [DW-1:0]     s_data, bus_data;
  logic [TW-1:0]     s_tag, bus_tag;
  logic              bus_valid, frame_done, err;

  xbus_feeder #(.DATA_WIDTH(DW), .NUM_COL(NC), .TAG_W(TW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .col_en(col_en), .tag_out(tag_out),
    .tag_lock(tag_lock), .cfg_done(cfg_done), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_tag(s_tag), .s_last(s_last), .bus_valid(bus_valid),
    .bus_data(bus_data), .bus_tag(bus_tag), .bus_ready(bus_ready),
    .frame_done(frame_done), .err(err));

  typedef struct { logic [DW-1:0] d; logic [TW-1:0] t; logic l; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int cyc_cnt = 0, fd_count = 0, fd_cyc = 0, acc_cyc = 0;
  logic [NC-1:0] col_en_m = '0;
  logic [NC-1:0] lk_d1 = '0, lk_d2 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc_cnt++; end

  // Each column acknowledges its tag two cycles after the tag is written.
  initial begin
    tag_lock = '0;
    forever begin
      @(negedge clk);
      lk_d2 = lk_d1;
      for (int k = 0; k < NC; k++) lk_d1[k] = tag_out[k*TW + TW-1];
      tag_lock = lk_d2;
    end
  end

  // Monitor: every retire pops one expected word.
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (bus_valid && (&(bus_ready | ~col_en_m))) begin
        if (exp_q.size() == 0) chk("retire_with_empty_queue", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("bus_data", 32'(bus_data), 32'(e.d));
          chk("bus_tag", 32'(bus_tag), 32'(e.t));
          chk("frame_done_on_retire", 32'(frame_done), 32'(e.l));
        end
      end else chk("stray_frame_done", 32'(frame_done), 0);
      if (frame_done) begin fd_count++; fd_cyc = cyc_cnt; end
    end
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic do_cfg(input logic [NC-1:0] c, output int n);
    col_en = c; col_en_m = c; cfg_start = 1;
    tick; cfg_start = 0;
    n = 0;
    while (!cfg_done && n < 40) begin tick; n++; end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic l);
    int n = 0;
    s_valid = 1; s_data = d; s_tag = t; s_last = l;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        exp_t e;
        e.d = d; e.t = t; e.l = l;
        exp_q.push_back(e);
        acc_cyc = cyc_cnt;
        tick;
        break;
      end
      tick; n++;
      if (n > 200) begin chk("accept_timeout", 1, 0); break; end
    end
  endtask

  task automatic do_reset;
    rstn = 0; s_valid = 0; cfg_start = 0;
    exp_q.delete();
    repeat (3) tick;
    rstn = 1;
  endtask

  initial begin
    int n, first;
    rstn = 0; cfg_start = 0; col_en = '0; bus_ready = '1;
    s_valid = 0; s_data = '0; s_tag = '0; s_last = 0;
    repeat (3) tick;
    rstn = 1;
    @(negedge clk);
    chk("rst_tag_out", 32'(tag_out), 0);
    chk("rst_bus_valid", 32'(bus_valid), 0);
    chk("rst_cfg_done", 32'(cfg_done), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_err", 32'(err), 0);
    tick;

    // s_valid in IDLE is never accepted.
    s_valid = 1; s_data = 16'hDEAD;
    repeat (2) begin @(negedge clk); chk("idle_s_ready", 32'(s_ready), 0); tick; end
    chk("idle_bus_valid", 32'(bus_valid), 0);
    s_valid = 0;

    // T1: all columns, 3 cycles each with the 2-cycle lock.
    do_cfg(4'b1111, n);
    chk("t1_cfg_cycles", 32'(n), 12);
    chk("t1_tag_out", 32'(tag_out), 32'h0FAC);

    // T3: 8 back-to-back words.
    fd_count = 0;
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), 3'(4 + (i % 4)), i == 8);
      if (i == 1) first = acc_cyc;
    end
    s_valid = 0;
    chk("t3_throughput", 32'(acc_cyc - first), 7);
    repeat (3) tick;
    chk("t3_fd_count", 32'(fd_count), 1);
    chk("t3_fd_latency", 32'(fd_cyc - first), 8);
    chk("t3_queue_empty", 32'(exp_q.size()), 0);

    // T4: column 1 stalls for 5 cycles.
    fd_count = 0;
    bus_ready = 4'b1101;
    send(16'h00A5, 3'b101, 1);
    s_valid = 0;
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(bus_valid), 1);
      chk("t4_hold_data", 32'(bus_data), 32'h00A5);
      chk("t4_hold_s_ready", 32'(s_ready), 0);
      tick;
    end
    bus_ready = 4'b1111;
    @(negedge clk);
    chk("t4_release_s_ready", 32'(s_ready), 1);
    tick;
    chk("t4_bus_valid_fall", 32'(bus_valid), 0);
    chk("t4_fd_count", 32'(fd_count), 1);

    // T5: reset while the last word of a frame is on the bus.
    fd_count = 0;
    send(16'h0001, 3'b100, 0);
    send(16'h0002, 3'b101, 0);
    send(16'h0003, 3'b110, 1);
    rstn = 0; s_valid = 0; exp_q.delete();
    @(negedge clk);
    chk("t5_fd_in_reset", 32'(frame_done), 0);
    tick; rstn = 1;
    chk("t5_bus_valid", 32'(bus_valid), 0);
    chk("t5_cfg_done", 32'(cfg_done), 0);
    chk("t5_tag_out", 32'(tag_out), 0);
    repeat (3) tick;
    chk("t5_fd_count", 32'(fd_count), 0);

    // T2: column 2 disabled, skipped in one cycle.
    do_cfg(4'b1011, n);
    chk("t2_cfg_cycles", 32'(n), 10);
    chk("t2_tag_out", 32'(tag_out), 32'h0E2C);
    fd_count = 0;
    bus_ready = 4'b1011;
    send(16'h1234, 3'b111, 1);
    s_valid = 0;
    repeat (2) tick;
    chk("t2_fd_count", 32'(fd_count), 1);

    // Restart from READY with no columns: tags cleared, every word retires.
    do_cfg(4'b0000, n);
    chk("none_cfg_cycles", 32'(n), 4);
    chk("none_tag_out", 32'(tag_out), 0);
    fd_count = 0;
    bus_ready = 4'b0000;
    send(16'h0055, 3'b000, 0);
    send(16'h0066, 3'b001, 1);
    s_valid = 0;
    repeat (2) tick;
    chk("none_fd_count", 32'(fd_count), 1);
    chk("none_queue_empty", 32'(exp_q.size()), 0);

`ifdef XBUS_TIMEOUT_EN
    // T6: permanent stall is force-retired after 16 cycles.
    do_reset;
    repeat (3) tick;
    bus_ready = 4'b1111;
    do_cfg(4'b1111, n);
    bus_ready = 4'b0000;
    send(16'h0BAD, 3'b100, 0);
    n = 0;
    while (bus_valid && n < 40) begin tick; n++; end
    chk("t6_stall_cycles", 32'(n), 16);
    chk("t6_err", 32'(err), 1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    bus_ready = 4'b1111;
    send(16'h0C0D, 3'b101, 1);
    s_valid = 0;
    repeat (2) tick;
    chk("t6_err_sticky", 32'(err), 1);
`else
    chk("err_tied_low", 32'(err), 0);
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
